// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// Optional feature macro: MC_JUMP_EN (adds the JUMP state for op 000010).
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Moore part of the control word; aluEn marks states that actually use the ALU
  typedef struct packed {
    logic       memReq;
    logic       iorD;
    logic       memWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       aluEn;
    aluop_t     aluOp;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       branch;
  } ctrl_t;

  // Control word for a given state; anything a state does not mention stays 0
  function automatic ctrl_t stateOutputs(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memReq  = 1'b1;
        c.aluSrcB = SRCB_FOUR;
        c.aluEn   = 1'b1;
        c.aluOp   = ALUOP_ADD;
        c.pcSrc   = PCSRC_ALU;
      end
      DECODE: begin
        c.aluSrcB = SRCB_IMMSH;
        c.aluEn   = 1'b1;
        c.aluOp   = ALUOP_ADD;
      end
      MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluEn   = 1'b1;
        c.aluOp   = ALUOP_ADD;
      end
      MEMREAD: begin
        c.memReq = 1'b1;
        c.iorD   = 1'b1;
      end
      MEMWB: begin
        c.memtoReg = 1'b1;
        c.regWrite = 1'b1;
      end
      MEMWRITE: begin
        c.memReq   = 1'b1;
        c.iorD     = 1'b1;
        c.memWrite = 1'b1;
      end
      EXECUTE: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_B;
        c.aluEn   = 1'b1;
        c.aluOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
      end
      BRANCH: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_B;
        c.aluEn   = 1'b1;
        c.aluOp   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.pcSrc   = PCSRC_ALUOUT;
      end
      ADDIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluEn   = 1'b1;
        c.aluOp   = ALUOP_ADD;
      end
      ADDIWB: begin
        c.regWrite = 1'b1;
      end
`ifdef MC_JUMP_EN
      JUMP: begin
        c.pcSrc   = PCSRC_JUMP;
        c.pcWrite = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle.
// master = control FSM, slave = datapath and memory side.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op, mem_timeout
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// ALU decoder: maps the FSM's coarse aluop plus funct to a 3-bit ALUControl.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  aluop_t     aluOp_i,
  input  logic [5:0] funct_i,
  output logic [2:0] aluControl_o
);

  // Add/sub are forced by the FSM; R-type uses funct, unknown funct falls back to AND
  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluOp_i)
      ALUOP_ADD: aluControl_o = ALU_ADD;
      ALUOP_SUB: aluControl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: aluControl_o = ALU_ADD;
          FUNCT_SUB: aluControl_o = ALU_SUB;
          FUNCT_AND: aluControl_o = ALU_AND;
          FUNCT_OR:  aluControl_o = ALU_OR;
          FUNCT_SLT: aluControl_o = ALU_SLT;
          default:   aluControl_o = ALU_AND;
        endcase
      end
      default: aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath with a memory wait timeout.
// Optional feature macro: MC_JUMP_EN (op 000010 goes through the JUMP state).
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STATE_W        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_controller_if.master   bus,
  output logic [STATE_W-1:0]        state_dbg
);

  localparam int              WCNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] waitCnt_q, waitCnt_d;
  ctrl_t             ctrl_q;
  logic              isWaitState;
  logic              limitHit;
  logic              timeoutPulse;
  logic              illegalPulse;
  logic              fetchDone;
  logic [2:0]        aluCtl;

  mc_alu_decoder u_alu_dec (
    .aluOp_i      (ctrl_q.aluOp),
    .funct_i      (bus.funct),
    .aluControl_o (aluCtl)
  );

  // Next state and wait counter; a stalled access at the limit aborts back to FETCH
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    timeoutPulse = 1'b0;
    illegalPulse = 1'b0;
    isWaitState  = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    limitHit     = TIMEOUT_EN && (waitCnt_q == WAIT_LIMIT);
    if (isWaitState && !bus.mem_ready) begin
      if (limitHit) begin
        timeoutPulse = 1'b1;
        state_d      = FETCH;
        waitCnt_d    = '0;
      end else if (TIMEOUT_EN) begin
        waitCnt_d = waitCnt_q + 1'b1;
      end
    end else begin
      waitCnt_d = '0;
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = EXECUTE;
            OP_BEQ:       state_d = BRANCH;
            OP_ADDI:      state_d = ADDIEX;
`ifdef MC_JUMP_EN
            OP_J:         state_d = JUMP;
`endif
            default: begin
              illegalPulse = 1'b1;
              state_d      = FETCH;
            end
          endcase
        end
        MEMADR:   state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  state_d = MEMWB;
        EXECUTE:  state_d = ALUWB;
        ADDIEX:   state_d = ADDIWB;
        default:  state_d = FETCH;
      endcase
    end
  end

  // State, wait counter and the registered Moore control word (preloaded for FETCH on reset)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      waitCnt_q <= '0;
      ctrl_q    <= stateOutputs(FETCH);
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      ctrl_q    <= stateOutputs(state_d);
    end
  end

  // Drive the bus; mem_ready qualifies the fetch writes and reset blanks everything
  always_comb begin
    fetchDone       = (state_q == FETCH) && bus.mem_ready;
    bus.mem_req     = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUControl  = 3'b000;
    bus.PCSrc       = 2'b00;
    bus.PCEn        = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = 1'b0;
    state_dbg       = '0;
    if (!reset) begin
      bus.mem_req     = ctrl_q.memReq;
      bus.IorD        = ctrl_q.iorD;
      bus.MemWrite    = ctrl_q.memWrite;
      bus.IRWrite     = fetchDone;
      bus.RegDst      = ctrl_q.regDst;
      bus.MemtoReg    = ctrl_q.memtoReg;
      bus.RegWrite    = ctrl_q.regWrite;
      bus.ALUSrcA     = ctrl_q.aluSrcA;
      bus.ALUSrcB     = ctrl_q.aluSrcB;
      bus.ALUControl  = ctrl_q.aluEn ? aluCtl : 3'b000;
      bus.PCSrc       = ctrl_q.pcSrc;
      bus.PCEn        = fetchDone | ctrl_q.pcWrite | (ctrl_q.branch & bus.zero);
      bus.illegal_op  = illegalPulse;
      bus.mem_timeout = timeoutPulse;
      state_dbg       = STATE_W'(state_q);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (built with TIMEOUT_CYCLES=4).
// Define MC_JUMP_EN for both bench and RTL to exercise the jump build.
module tb_multicycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JOP = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SLT = 6'b101010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] stateDbg;
  int         total = 0;
  int         bad = 0;

  multicycle_controller_if bus();

  multicycle_controller #(.TIMEOUT_CYCLES(4), .STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .state_dbg (stateDbg)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  function automatic logic [22:0] allOuts();
    return {bus.mem_req, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc, bus.PCEn,
            bus.illegal_op, bus.mem_timeout, stateDbg};
  endfunction

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
    bus.op = o; bus.funct = f; bus.zero = z; bus.mem_ready = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(RT, F_ADD, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (allOuts() !== '0) begin bad++; $display("FAIL reset_outs got=%h want=0", allOuts()); end
    @(posedge clk); #1 reset = 1'b0;
    drive(LW, 6'd0, 1'b0, 1'b0);
    #1;
    total++;
    if ({bus.mem_req, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, stateDbg} !== {3'b100, 2'b01, 3'b010, 4'd0}) begin
      bad++; $display("FAIL reset_fetch got=%b", {bus.mem_req, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, stateDbg});
    end
    tick();
  endtask

  task automatic test_lw();
    int expS[5] = '{0, 1, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      drive(LW, 6'd0, 1'b0, 1'b1);
      @(negedge clk);
      total++;
      if (stateDbg !== 4'(expS[i])) begin bad++; $display("FAIL lw_state cyc%0d got=%0d want=%0d", i, stateDbg, expS[i]); end
      total++;
      if (bus.PCEn !== (i == 0)) begin bad++; $display("FAIL lw_pcen cyc%0d got=%b want=%b", i, bus.PCEn, i == 0); end
      total++;
      if ({bus.RegWrite, bus.MemtoReg} !== ((i == 4) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL lw_wb cyc%0d got=%b", i, {bus.RegWrite, bus.MemtoReg});
      end
      tick();
    end
  endtask

  task automatic test_sw_wait();
    logic rdy[7] = '{1, 1, 1, 0, 0, 0, 1};
    int   expS[7] = '{0, 1, 2, 5, 5, 5, 5};
    for (int i = 0; i < 7; i++) begin
      drive(SW, 6'd0, 1'b0, rdy[i]);
      @(negedge clk);
      total++;
      if ({stateDbg, bus.MemWrite, bus.RegWrite} !== {4'(expS[i]), i >= 3, 1'b0}) begin
        bad++; $display("FAIL sw_cycle cyc%0d got st=%0d mw=%b rw=%b want st=%0d mw=%b", i, stateDbg, bus.MemWrite, bus.RegWrite, expS[i], i >= 3);
      end
      tick();
    end
    drive(SW, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (stateDbg !== 4'd0) begin bad++; $display("FAIL sw_return got=%0d want=0", stateDbg); end
    tick();
  endtask

  task automatic test_back_to_back();
    int expS[4] = '{0, 1, 6, 7};
    for (int k = 0; k < 2; k++) begin
      logic [5:0] f;
      logic [2:0] expAlu;
      f = (k == 1) ? F_SLT : F_ADD;
      expAlu = (k == 1) ? 3'b111 : 3'b010;
      for (int i = 0; i < 4; i++) begin
        drive(RT, f, 1'b0, 1'b1);
        @(negedge clk);
        total++;
        if (stateDbg !== 4'(expS[i])) begin bad++; $display("FAIL rtype_state k%0d cyc%0d got=%0d want=%0d", k, i, stateDbg, expS[i]); end
        if (i == 2) begin
          total++;
          if (bus.ALUControl !== expAlu) begin bad++; $display("FAIL rtype_alu k%0d got=%b want=%b", k, bus.ALUControl, expAlu); end
        end
        if (i == 3) begin
          total++;
          if ({bus.RegDst, bus.RegWrite, bus.MemtoReg} !== 3'b110) begin
            bad++; $display("FAIL rtype_wb k%0d got=%b want=110", k, {bus.RegDst, bus.RegWrite, bus.MemtoReg});
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      logic z;
      z = (k == 0);
      for (int i = 0; i < 3; i++) begin
        drive(BEQ, 6'd0, z, 1'b1);
        @(negedge clk);
        if (i == 2) begin
          total++;
          if ({stateDbg, bus.PCEn, bus.PCSrc, bus.ALUControl} !== {4'd8, z, 2'b01, 3'b110}) begin
            bad++; $display("FAIL beq_branch z=%b got st=%0d pcen=%b pcsrc=%b alu=%b", z, stateDbg, bus.PCEn, bus.PCSrc, bus.ALUControl);
          end
        end
        tick();
      end
      drive(BEQ, 6'd0, z, 1'b0);
      @(negedge clk);
      total++;
      if (stateDbg !== 4'd0) begin bad++; $display("FAIL beq_return z=%b got=%0d want=0", z, stateDbg); end
      tick();
    end
  endtask

  task automatic test_illegal();
    drive(6'b111111, 6'd0, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    total++;
    if ({stateDbg, bus.illegal_op} !== {4'd1, 1'b1}) begin bad++; $display("FAIL illegal_decode got st=%0d ill=%b", stateDbg, bus.illegal_op); end
    tick();
    drive(6'b111111, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if ({stateDbg, bus.illegal_op} !== {4'd0, 1'b0}) begin bad++; $display("FAIL illegal_next got st=%0d ill=%b", stateDbg, bus.illegal_op); end
    tick();
    drive(JOP, 6'd0, 1'b0, 1'b1);
    tick();
    @(negedge clk);
`ifdef MC_JUMP_EN
    total++;
    if (bus.illegal_op !== 1'b0) begin bad++; $display("FAIL jump_decode got ill=%b want=0", bus.illegal_op); end
    tick();
    @(negedge clk);
    total++;
    if ({stateDbg, bus.PCEn, bus.PCSrc} !== {4'd11, 1'b1, 2'b10}) begin
      bad++; $display("FAIL jump_state got st=%0d pcen=%b pcsrc=%b", stateDbg, bus.PCEn, bus.PCSrc);
    end
    tick();
`else
    total++;
    if (bus.illegal_op !== 1'b1) begin bad++; $display("FAIL jump_illegal got ill=%b want=1", bus.illegal_op); end
    tick();
`endif
    drive(JOP, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if ({stateDbg, bus.PCSrc} !== {4'd0, 2'b00}) begin bad++; $display("FAIL jump_return got st=%0d pcsrc=%b", stateDbg, bus.PCSrc); end
    tick();
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin drive(LW, 6'd0, 1'b0, 1'b1); tick(); end
      for (int i = 0; i < 5; i++) begin
        logic r;
        r = (k == 1) && (i == 4);
        drive(LW, 6'd0, 1'b0, r);
        @(negedge clk);
        total++;
        if ({stateDbg, bus.mem_timeout, bus.RegWrite} !== {4'd3, (k == 0) && (i == 4), 1'b0}) begin
          bad++; $display("FAIL timeout_wait k%0d cyc%0d got st=%0d tmo=%b rw=%b", k, i, stateDbg, bus.mem_timeout, bus.RegWrite);
        end
        tick();
      end
      drive(LW, 6'd0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({stateDbg, bus.mem_timeout, bus.RegWrite} !== ((k == 0) ? {4'd0, 2'b00} : {4'd4, 2'b01})) begin
        bad++; $display("FAIL timeout_after k%0d got st=%0d tmo=%b rw=%b", k, stateDbg, bus.mem_timeout, bus.RegWrite);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(RT, F_ADD, 1'b0, 1'b1);
    tick();
    tick();
    @(negedge clk);
    total++;
    if (stateDbg !== 4'd6) begin bad++; $display("FAIL midrst_exec got=%0d want=6", stateDbg); end
    #1 reset = 1'b1;
    #1;
    total++;
    if (allOuts() !== '0) begin bad++; $display("FAIL midrst_outs got=%h want=0", allOuts()); end
    @(posedge clk); #1 reset = 1'b0;
    drive(RT, F_ADD, 1'b0, 1'b0);
    #1;
    total++;
    if ({stateDbg, bus.mem_req, bus.RegWrite} !== {4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL midrst_release got st=%0d req=%b rw=%b", stateDbg, bus.mem_req, bus.RegWrite);
    end
    tick();
  endtask

  // Reference model: each instruction class is a list of phase codes; memory phases
  // stretch while mem_ready is low and abort after four idle cycles.
  task automatic test_random();
    logic [5:0] ops[7] = '{LW, SW, RT, ADDI, BEQ, JOP, 6'b111111};
    for (int n = 0; n < 60; n++) begin
      int q[$];
      int idx, waits, ph;
      logic [5:0] o;
      logic illegal, r, z, isMem, tmo;
      logic [6:0] expV, gotV;
      o = ops[$urandom_range(0, 6)];
      q = '{0, 1};
      illegal = 1'b0;
      case (o)
        LW:   q = '{0, 1, 2, 3, 4};
        SW:   q = '{0, 1, 2, 5};
        RT:   q = '{0, 1, 6, 7};
        ADDI: q = '{0, 1, 9, 10};
        BEQ:  q = '{0, 1, 8};
`ifdef MC_JUMP_EN
        JOP:  q = '{0, 1, 11};
`endif
        default: illegal = 1'b1;
      endcase
      idx = 0;
      waits = 0;
      while (idx < q.size()) begin
        ph = q[idx];
        r = ($urandom_range(0, 3) != 0);
        z = 1'($urandom_range(0, 1));
        drive(o, 6'($urandom), z, r);
        isMem = (ph == 0) || (ph == 3) || (ph == 5);
        tmo = isMem && !r && (waits == 4);
        expV = {isMem, ph == 5, (ph == 0) && r, (ph == 4) || (ph == 7) || (ph == 10),
                ((ph == 0) && r) || ((ph == 8) && z) || (ph == 11), (ph == 1) && illegal, tmo};
        @(negedge clk);
        gotV = {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCEn, bus.illegal_op, bus.mem_timeout};
        total++;
        if (stateDbg !== 4'(ph)) begin bad++; $display("FAIL rand_state n%0d op=%b got=%0d want=%0d", n, o, stateDbg, ph); end
        total++;
        if (gotV !== expV) begin bad++; $display("FAIL rand_ctrl n%0d op=%b ph=%0d got=%b want=%b", n, o, ph, gotV, expV); end
        tick();
        if (!isMem) idx++;
        else if (r) begin idx++; waits = 0; end
        else if (tmo) begin
          waits = 0;
          if (ph != 0) idx = q.size();
        end else waits++;
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath.
- The datapath uses one shared instruction/data memory, one ALU, and IR/A/B/ALUOut registers.
- This block replaces the single-cycle combinational control unit.
- It decodes op/funct over several cycles and drives mux selects, register enables and the memory handshake.
- It covers lw, sw, R-type (add/sub/and/or/slt), addi and beq; j is optional.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for mem_ready in a memory state before aborting to FETCH. 0 disables the timeout.
- STATE_W, 4: width of the state register and of state_dbg.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemWrite  out  1  write strobe to memory
- IRWrite  out  1  load IR
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = Data register
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  ADD 010, SUB 110, AND 000, OR 001, SLT 111
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse on a wait abort
- state_dbg  out  STATE_W  current state

Behaviour:
- Reset:
  - Asynchronous; state = FETCH and wait counter = 0.
  - While reset is high, every output is forced to 0.
  - After release, FETCH outputs take effect in the same cycle.
- Outputs:
  - All outputs are decoded from state only, except:
    - qualifiers on mem_ready;
    - PCEn = PCWrite | (Branch & zero), combinational.
  - Unlisted outputs are 0.
- States and transitions:
  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU ADD, PCSrc=00. IRWrite and PCWrite assert only in the cycle mem_ready=1. Stay until mem_ready, then go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ADD (precompute branch target).
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - otherwise pulse illegal_op and go to FETCH
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: mem_req=1, IorD=1. Wait for mem_ready, then go to MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
  - MEMWRITE: mem_req=1, IorD=1, MemWrite=1 held until mem_ready. The write commits on the mem_ready cycle, then FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl comes from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct gives AND. Then ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, Branch=1, PCSrc=01, then FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD, then ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- Wait counter:
  - Counts cycles in FETCH/MEMREAD/MEMWRITE while mem_ready=0.
  - Cleared on every state change.
  - If it reaches TIMEOUT_CYCLES (and the parameter is nonzero): pulse mem_timeout, go to FETCH, no PC/IR/register/memory update.
  - If mem_ready arrives in the same cycle as the limit, mem_ready wins.
- Latency with mem_ready tied high: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Reset mid-instruction: the instruction is abandoned and no partial writeback occurs.

Optional Feature:
- MC_JUMP_EN defined:
  - op 000010 goes DECODE -> JUMP.
  - JUMP: PCSrc=10, PCWrite=1, then FETCH.
- Undefined:
  - op 000010 is illegal: illegal_op pulses and control returns to FETCH.
  - PCSrc never equals 10.

Decomposition:
- Package mc_pkg holds:
  - state enum (FETCH=0 … ADDIWB=10, JUMP=11);
  - opcode constants (LW 100011, SW 101011, RTYPE 000000, ADDI 001000, BEQ 000100, J 000010);
  - funct constants;
  - ALUControl codes;
  - ALUSrcB/PCSrc select codes.
- Sub-module mc_alu_decoder: combinational aluop (00 add / 01 sub / 10 funct) plus funct -> ALUControl. The FSM drives aluop.

Test Plan:
- lw with mem_ready=1: state sequence 0,1,2,3,4. RegWrite=1 and MemtoReg=1 only in cycle 5. PCEn exactly once, in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWRITE: MemWrite held 4 cycles. Commit on the mem_ready cycle, then FETCH. RegWrite never asserted.
- Back-to-back R-type instructions:
  - add: funct 100000 -> ALUControl 010 in EXECUTE, RegDst=1 in ALUWB.
  - slt: funct 101010 -> 111.
- beq with zero=1: PCEn=1 in BRANCH with PCSrc=01. With zero=0: PCEn=0. Both take 3 cycles.
- op 111111 -> illegal_op pulses in the DECODE cycle, next state FETCH. op 000010 behaves per MC_JUMP_EN; run the bench both ways.
- TIMEOUT_CYCLES=4 with mem_ready stuck low in MEMREAD: mem_timeout after 4 wait cycles, return to FETCH. Separately, assert reset mid-EXECUTE: outputs 0 immediately, state_dbg=0.
